// File: rtl/toy_fetch_inst_queue_pkg.sv
// rtl/toy_fetch_inst_queue_pkg.sv - shared sizing constants and helpers for the fetch instruction queue
package toy_fetch_inst_queue_pkg;

    localparam int INST_WIDTH       = 32;
    localparam int FETCH_INST_NUM   = 4;
    localparam int FETCH_DATA_WIDTH = 128;
    localparam int IQ_DEPTH         = 16;
    localparam int DEC_WIDTH        = 2;
    localparam int IQ_PTR_WIDTH     = $clog2(IQ_DEPTH);
    localparam int PTR_WIDTH        = IQ_PTR_WIDTH + 1;

    localparam bit FETCH_SPLIT_OK = (FETCH_DATA_WIDTH == FETCH_INST_NUM * INST_WIDTH);
    localparam bit DEPTH_OK       = ((IQ_DEPTH & (IQ_DEPTH - 1)) == 0) && ((IQ_DEPTH % FETCH_INST_NUM) == 0);
    localparam bit DEC_OK         = (DEC_WIDTH <= FETCH_INST_NUM);

    // Pointers and count share one width: the extra top bit is the wrap bit.
    typedef logic [PTR_WIDTH-1:0] iq_ptr_t;

    function automatic iq_ptr_t popcount_dec(input logic [DEC_WIDTH-1:0] v);
        iq_ptr_t n;
        n = '0;
        for (int i = 0; i < DEC_WIDTH; i++) begin
            n = n + iq_ptr_t'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/toy_fetch_inst_queue_if.sv
// rtl/toy_fetch_inst_queue_if.sv - fetch-in / decode-out handshake bundle for the instruction queue
interface toy_fetch_inst_queue_if;
    import toy_fetch_inst_queue_pkg::*;

    logic                              filter_vld;
    logic                              filter_rdy;
    logic [FETCH_DATA_WIDTH-1:0]       filter_pld;
    logic [DEC_WIDTH-1:0]              dec_vld;
    logic [DEC_WIDTH*INST_WIDTH-1:0]   dec_pld;
    logic                              dec_rdy;
    logic                              fe_ctrl_flush;
    logic                              iq_empty;

    modport master (
        output filter_vld, filter_pld, dec_rdy, fe_ctrl_flush,
        input  filter_rdy, dec_vld, dec_pld, iq_empty
    );

    modport slave (
        input  filter_vld, filter_pld, dec_rdy, fe_ctrl_flush,
        output filter_rdy, dec_vld, dec_pld, iq_empty
    );

endinterface

// File: rtl/toy_fetch_inst_queue.sv
// rtl/toy_fetch_inst_queue.sv - circular instruction queue splitting fetch packets into decode lanes
module toy_fetch_inst_queue
    import toy_fetch_inst_queue_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    toy_fetch_inst_queue_if.slave  iq_if
);

    if (!FETCH_SPLIT_OK) begin : g_bad_split
        $error("FETCH_DATA_WIDTH must equal FETCH_INST_NUM*INST_WIDTH");
    end
    if (!DEPTH_OK) begin : g_bad_depth
        $error("IQ_DEPTH must be a power of 2 and a multiple of FETCH_INST_NUM");
    end
    if (!DEC_OK) begin : g_bad_dec
        $error("DEC_WIDTH must not exceed FETCH_INST_NUM");
    end

    logic [INST_WIDTH-1:0]             mem_q [IQ_DEPTH];
    iq_ptr_t                           wr_ptr_q, wr_ptr_d;
    iq_ptr_t                           rd_ptr_q, rd_ptr_d;
    iq_ptr_t                           count_q, count_d;
    iq_ptr_t                           pop_n;
    logic                              push;
    logic                              filter_rdy;
    logic [DEC_WIDTH-1:0]              dec_vld;
    logic [DEC_WIDTH*INST_WIDTH-1:0]   dec_pld;
    logic [IQ_PTR_WIDTH-1:0]           wr_idx [FETCH_INST_NUM];
    logic [IQ_PTR_WIDTH-1:0]           rd_idx [DEC_WIDTH];

    // Acceptance looks only at the registered count; lanes leaving this cycle do not free space early.
    assign filter_rdy = ~iq_if.fe_ctrl_flush &&
                        (count_q <= iq_ptr_t'(IQ_DEPTH - FETCH_INST_NUM));
    assign push       = iq_if.filter_vld && filter_rdy;

    always_comb begin
        dec_vld = '0;
        for (int k = 0; k < DEC_WIDTH; k++) begin
            dec_vld[k] = ~iq_if.fe_ctrl_flush && (count_q > iq_ptr_t'(k));
        end
    end

    assign pop_n = iq_if.dec_rdy ? popcount_dec(dec_vld) : '0;

    always_comb begin
        for (int k = 0; k < FETCH_INST_NUM; k++) begin
            wr_idx[k] = wr_ptr_q[IQ_PTR_WIDTH-1:0] + IQ_PTR_WIDTH'(k);
        end
        for (int k = 0; k < DEC_WIDTH; k++) begin
            rd_idx[k] = rd_ptr_q[IQ_PTR_WIDTH-1:0] + IQ_PTR_WIDTH'(k);
        end
    end

    // Storage is deliberately left unreset; validity is carried entirely by count.
    always_ff @(posedge clk) begin
        for (int e = 0; e < IQ_DEPTH; e++) begin
            for (int k = 0; k < FETCH_INST_NUM; k++) begin
                if (push && (wr_idx[k] == IQ_PTR_WIDTH'(e))) begin
                    mem_q[e] <= iq_if.filter_pld[k*INST_WIDTH +: INST_WIDTH];
                end
            end
        end
    end

    always_comb begin
        dec_pld = '0;
        for (int k = 0; k < DEC_WIDTH; k++) begin
            dec_pld[k*INST_WIDTH +: INST_WIDTH] = mem_q[rd_idx[k]];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (iq_if.fe_ctrl_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + iq_ptr_t'(FETCH_INST_NUM);
            end
            rd_ptr_d = rd_ptr_q + pop_n;
            count_d  = count_q + (push ? iq_ptr_t'(FETCH_INST_NUM) : '0) - pop_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign iq_if.filter_rdy = filter_rdy;
    assign iq_if.dec_vld    = dec_vld;
    assign iq_if.dec_pld    = dec_pld;
    assign iq_if.iq_empty   = (count_q == '0);

endmodule

// File: tb/tb_toy_fetch_inst_queue.sv
// tb/tb_toy_fetch_inst_queue.sv - directed self-checking bench for toy_fetch_inst_queue
module tb_toy_fetch_inst_queue;
    import toy_fetch_inst_queue_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    toy_fetch_inst_queue_if iq_if ();

    toy_fetch_inst_queue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iq_if (iq_if)
    );

    always #5 clk = ~clk;

    function automatic logic [FETCH_DATA_WIDTH-1:0] mk_pkt(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Structural invariant: count tracks the pointer distance and never exceeds the depth.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (dut.count_q !== iq_ptr_t'(dut.wr_ptr_q - dut.rd_ptr_q)) begin
                errors++;
                $display("FAIL inv_count_ptr: count=%0d wr=%0d rd=%0d", dut.count_q, dut.wr_ptr_q, dut.rd_ptr_q);
            end
            checks++;
            if (dut.count_q > iq_ptr_t'(IQ_DEPTH)) begin
                errors++;
                $display("FAIL inv_count_max: count=%0d limit=%0d", dut.count_q, IQ_DEPTH);
            end
        end
    end

    task automatic test_reset();
        rst_n               = 1'b0;
        iq_if.filter_vld    = 1'b0;
        iq_if.filter_pld    = '0;
        iq_if.dec_rdy       = 1'b0;
        iq_if.fe_ctrl_flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (iq_if.filter_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", iq_if.filter_rdy); end
        checks++; if (iq_if.dec_vld !== 2'b00) begin errors++; $display("FAIL reset_vld: got %b want 00", iq_if.dec_vld); end
        checks++; if (iq_if.iq_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", iq_if.iq_empty); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_packet();
        iq_if.filter_vld = 1'b1;
        iq_if.filter_pld = {32'h193, 32'h113, 32'h93, 32'h13};
        iq_if.dec_rdy    = 1'b1;
        @(negedge clk);
        checks++; if (iq_if.filter_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b want 1", iq_if.filter_rdy); end
        checks++; if (iq_if.dec_vld !== 2'b00) begin errors++; $display("FAIL single_no_bypass: got %b want 00", iq_if.dec_vld); end
        step();
        iq_if.filter_vld = 1'b0;
        @(negedge clk);
        checks++; if (iq_if.dec_vld !== 2'b11) begin errors++; $display("FAIL single_vld1: got %b want 11", iq_if.dec_vld); end
        checks++; if (iq_if.dec_pld !== {32'h93, 32'h13}) begin errors++; $display("FAIL single_pld1: got %h want %h", iq_if.dec_pld, {32'h93, 32'h13}); end
        step();
        @(negedge clk);
        checks++; if (iq_if.dec_pld !== {32'h193, 32'h113}) begin errors++; $display("FAIL single_pld2: got %h want %h", iq_if.dec_pld, {32'h193, 32'h113}); end
        step();
        @(negedge clk);
        checks++; if (iq_if.iq_empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b want 1", iq_if.iq_empty); end
        checks++; if (iq_if.dec_vld !== 2'b00) begin errors++; $display("FAIL single_vld_end: got %b want 00", iq_if.dec_vld); end
        step();
        @(negedge clk);
        checks++; if (dut.count_q !== iq_ptr_t'(0)) begin errors++; $display("FAIL idle_rdy_noop: count=%0d want 0", dut.count_q); end
        iq_if.dec_rdy = 1'b0;
        step();
    endtask

    task automatic test_fill_stall();
        iq_if.dec_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iq_if.filter_vld = 1'b1;
            iq_if.filter_pld = mk_pkt(32'h1000 * (i + 1));
            @(negedge clk);
            checks++; if (iq_if.filter_rdy !== 1'b1) begin errors++; $display("FAIL fill_rdy%0d: got %b want 1", i, iq_if.filter_rdy); end
            step();
        end
        iq_if.filter_pld = mk_pkt(32'h5000);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (iq_if.filter_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy%0d: got %b want 0", c, iq_if.filter_rdy); end
            checks++; if (dut.count_q !== iq_ptr_t'(16)) begin errors++; $display("FAIL full_count%0d: got %0d want 16", c, dut.count_q); end
            checks++; if (iq_if.dec_pld !== {32'h1001, 32'h1000}) begin errors++; $display("FAIL full_hold_pld%0d: got %h want %h", c, iq_if.dec_pld, {32'h1001, 32'h1000}); end
            step();
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] exp [14];
        exp = '{32'h2002, 32'h2003, 32'h3000, 32'h3001, 32'h3002, 32'h3003, 32'h4000,
                32'h4001, 32'h4002, 32'h4003, 32'h5000, 32'h5001, 32'h5002, 32'h5003};
        iq_if.dec_rdy = 1'b1;
        @(negedge clk);
        checks++; if (iq_if.filter_rdy !== 1'b0) begin errors++; $display("FAIL nocredit_rdy16: got %b want 0", iq_if.filter_rdy); end
        checks++; if (iq_if.dec_pld !== {32'h1001, 32'h1000}) begin errors++; $display("FAIL pop_pld0: got %h", iq_if.dec_pld); end
        step();
        @(negedge clk);
        checks++; if (iq_if.filter_rdy !== 1'b0) begin errors++; $display("FAIL nocredit_rdy14: got %b want 0", iq_if.filter_rdy); end
        checks++; if (dut.count_q !== iq_ptr_t'(14)) begin errors++; $display("FAIL pop_count14: got %0d want 14", dut.count_q); end
        step();
        @(negedge clk);
        checks++; if (iq_if.filter_rdy !== 1'b1) begin errors++; $display("FAIL accept_rdy12: got %b want 1", iq_if.filter_rdy); end
        checks++; if (iq_if.dec_pld !== {32'h2001, 32'h2000}) begin errors++; $display("FAIL pushpop_pld: got %h want %h", iq_if.dec_pld, {32'h2001, 32'h2000}); end
        step();
        iq_if.filter_vld = 1'b0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (j == 0) begin
                checks++; if (dut.count_q !== iq_ptr_t'(14)) begin errors++; $display("FAIL pushpop_count: got %0d want 14", dut.count_q); end
            end
            checks++;
            if (iq_if.dec_vld !== 2'b11 || iq_if.dec_pld !== {exp[2*j+1], exp[2*j]}) begin
                errors++;
                $display("FAIL drain%0d: vld=%b pld=%h want 11 %h", j, iq_if.dec_vld, iq_if.dec_pld, {exp[2*j+1], exp[2*j]});
            end
            step();
        end
        @(negedge clk);
        checks++; if (iq_if.iq_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", iq_if.iq_empty); end
        iq_if.dec_rdy = 1'b0;
        step();
    endtask

    task automatic test_flush();
        iq_if.dec_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iq_if.filter_vld = 1'b1;
            iq_if.filter_pld = mk_pkt(32'h6000 + 32'h1000 * i);
            step();
        end
        iq_if.filter_vld = 1'b0;
        iq_if.dec_rdy    = 1'b1;
        step();
        iq_if.fe_ctrl_flush = 1'b1;
        iq_if.filter_vld    = 1'b1;
        iq_if.filter_pld    = mk_pkt(32'h9000);
        @(negedge clk);
        checks++; if (dut.count_q !== iq_ptr_t'(10)) begin errors++; $display("FAIL flush_pre_count: got %0d want 10", dut.count_q); end
        checks++; if (iq_if.filter_rdy !== 1'b0) begin errors++; $display("FAIL flush_rdy: got %b want 0", iq_if.filter_rdy); end
        checks++; if (iq_if.dec_vld !== 2'b00) begin errors++; $display("FAIL flush_vld: got %b want 00", iq_if.dec_vld); end
        step();
        iq_if.fe_ctrl_flush = 1'b0;
        @(negedge clk);
        checks++; if (iq_if.iq_empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b want 1", iq_if.iq_empty); end
        checks++; if (dut.rd_ptr_q !== iq_ptr_t'(0)) begin errors++; $display("FAIL flush_rdptr: got %0d want 0", dut.rd_ptr_q); end
        checks++; if (iq_if.filter_rdy !== 1'b1) begin errors++; $display("FAIL flush_after_rdy: got %b want 1", iq_if.filter_rdy); end
        step();
        iq_if.filter_vld = 1'b0;
        iq_if.dec_rdy    = 1'b0;
        @(negedge clk);
        checks++; if (iq_if.dec_pld !== {32'h9001, 32'h9000}) begin errors++; $display("FAIL flush_new_pld: got %h want %h", iq_if.dec_pld, {32'h9001, 32'h9000}); end
        checks++; if (dut.wr_ptr_q !== iq_ptr_t'(4)) begin errors++; $display("FAIL flush_new_wrptr: got %0d want 4", dut.wr_ptr_q); end
        step();
        iq_if.fe_ctrl_flush = 1'b1;
        iq_if.filter_vld    = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (iq_if.filter_rdy !== 1'b0) begin errors++; $display("FAIL held_flush_rdy%0d: got %b want 0", c, iq_if.filter_rdy); end
            step();
        end
        iq_if.fe_ctrl_flush = 1'b0;
        iq_if.filter_vld    = 1'b0;
        @(negedge clk);
        checks++; if (iq_if.iq_empty !== 1'b1) begin errors++; $display("FAIL held_flush_empty: got %b want 1", iq_if.iq_empty); end
        step();
    endtask

    task automatic test_wrap();
        logic [31:0]          sb [$];
        int                   mcount = 0;
        int                   pushed = 0;
        logic                 exp_rdy;
        logic [DEC_WIDTH-1:0] exp_vld;
        iq_if.dec_rdy = 1'b1;
        for (int cyc = 0; cyc < 40 && (pushed < 6 || mcount > 0); cyc++) begin
            iq_if.filter_vld = (pushed < 6);
            iq_if.filter_pld = mk_pkt(32'hA000 + 32'h10 * pushed);
            exp_rdy = (mcount <= 12);
            exp_vld = (mcount >= 2) ? 2'b11 : (mcount == 1) ? 2'b01 : 2'b00;
            @(negedge clk);
            checks++; if (iq_if.filter_rdy !== exp_rdy) begin errors++; $display("FAIL wrap_rdy c%0d: got %b want %b", cyc, iq_if.filter_rdy, exp_rdy); end
            checks++; if (iq_if.dec_vld !== exp_vld) begin errors++; $display("FAIL wrap_vld c%0d: got %b want %b", cyc, iq_if.dec_vld, exp_vld); end
            if (mcount >= 1) begin
                checks++; if (iq_if.dec_pld[31:0] !== sb[0]) begin errors++; $display("FAIL wrap_lane0 c%0d: got %h want %h", cyc, iq_if.dec_pld[31:0], sb[0]); end
            end
            if (mcount >= 2) begin
                checks++; if (iq_if.dec_pld[63:32] !== sb[1]) begin errors++; $display("FAIL wrap_lane1 c%0d: got %h want %h", cyc, iq_if.dec_pld[63:32], sb[1]); end
            end
            for (int k = 0; k < DEC_WIDTH; k++) begin
                if (exp_vld[k]) begin
                    void'(sb.pop_front());
                    mcount--;
                end
            end
            if (iq_if.filter_vld && exp_rdy) begin
                for (int k = 0; k < FETCH_INST_NUM; k++) sb.push_back(32'hA000 + 32'h10 * pushed + k);
                mcount += 4;
                pushed++;
            end
            step();
        end
        iq_if.filter_vld = 1'b0;
        iq_if.dec_rdy    = 1'b0;
        @(negedge clk);
        checks++; if (pushed != 6 || mcount != 0) begin errors++; $display("FAIL wrap_timeout: pushed=%0d left=%0d want 6 0", pushed, mcount); end
        checks++; if (dut.wr_ptr_q !== iq_ptr_t'(24)) begin errors++; $display("FAIL wrap_wrptr: got %0d want 24", dut.wr_ptr_q); end
        checks++; if (dut.rd_ptr_q[IQ_PTR_WIDTH] !== 1'b1) begin errors++; $display("FAIL wrap_bit: got %b want 1", dut.rd_ptr_q[IQ_PTR_WIDTH]); end
        checks++; if (iq_if.iq_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", iq_if.iq_empty); end
        step();
    endtask

    task automatic test_reset_mid();
        iq_if.filter_vld = 1'b1;
        iq_if.filter_pld = mk_pkt(32'hB000);
        step();
        iq_if.filter_vld = 1'b0;
        @(negedge clk);
        checks++; if (iq_if.dec_vld !== 2'b11) begin errors++; $display("FAIL midrst_pre_vld: got %b want 11", iq_if.dec_vld); end
        rst_n = 1'b0;
        #1;
        checks++; if (iq_if.iq_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b want 1", iq_if.iq_empty); end
        checks++; if (iq_if.dec_vld !== 2'b00) begin errors++; $display("FAIL midrst_vld: got %b want 00", iq_if.dec_vld); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_fill_stall();
        test_full_pop();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
